// File: rtl/sram_port_arbiter_if.sv
// SRAM port arbiter bus: per-channel requests in, grant/tags and
// the muxed SRAM controller port out.
interface sram_port_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_we_n;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        rd_valid;
  logic [ADDR_W-1:0]        SRAM_address;
  logic [DATA_W-1:0]        SRAM_write_data;
  logic                     SRAM_we_n;
  logic                     busy;

  modport master (
    output req, ch_addr, ch_wdata, ch_we_n,
    input  grant, rd_valid, SRAM_address,
    input  SRAM_write_data, SRAM_we_n, busy
  );

  modport slave (
    input  req, ch_addr, ch_wdata, ch_we_n,
    output grant, rd_valid, SRAM_address,
    output SRAM_write_data, SRAM_we_n, busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// N-channel owner arbiter for the single SRAM controller port, with
// bounded bursts, a turnaround cycle and read-data tag return.
module sram_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int RR_MODE   = 0,
  parameter int MAX_BURST = 64,
  parameter int READ_LAT  = 2
) (
  input logic Clock,
  input logic Reset,
  sram_port_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t            state;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last_owner;
  logic [7:0]        burst_cnt;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              win_ok;
  logic              any_grant;
  logic              rival;
  logic              own_we_n;
  logic [READ_LAT-1:0] tag_v;
  logic [IDX_W-1:0]  tag_idx [READ_LAT];

  function automatic logic [NUM_CH-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  // Search order starts at 0 (fixed) or just past the last owner (RR)
  always_comb begin
    win    = '0;
    cand   = '0;
    win_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0)
        cand = IDX_W'((int'(last_owner) + 1 + k) % NUM_CH);
      else
        cand = IDX_W'(k);
      if (!win_ok && bus.req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  assign any_grant = |grant;
  assign rival     = |(bus.req & ~grant);
  assign own_we_n  = bus.ch_we_n[owner];

  assign bus.grant = grant;
  assign bus.busy  = (state != S_IDLE);
  assign bus.SRAM_address =
    any_grant ? bus.ch_addr[owner*ADDR_W +: ADDR_W] : '0;
  assign bus.SRAM_write_data =
    any_grant ? bus.ch_wdata[owner*DATA_W +: DATA_W] : '0;
  assign bus.SRAM_we_n = any_grant ? own_we_n : 1'b1;
  assign bus.rd_valid =
    tag_v[READ_LAT-1] ? onehot(tag_idx[READ_LAT-1]) : '0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_CH - 1);
      burst_cnt  <= '0;
      tag_v      <= '0;
      for (int i = 0; i < READ_LAT; i++)
        tag_idx[i] <= '0;
    end else begin
      // Tags shift in every state so reads finish after handover
      tag_v[0]   <= any_grant && own_we_n;
      tag_idx[0] <= owner;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      unique case (state)
        S_IDLE, S_TURN: begin
          if (win_ok) begin
            grant      <= onehot(win);
            owner      <= win;
            last_owner <= win;
            burst_cnt  <= 8'd1;
            state      <= S_OWN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (!bus.req[owner] ||
              (rival && burst_cnt == BURST_MAX)) begin
            grant <= '0;
            state <= S_TURN;
          end else if (burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: fixed-priority and round-robin arbiters side by side,
// grant and read-tag expectations queued at stimulus time.
module tb_sram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) a();
  sram_port_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) b();

  sram_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(0), .MAX_BURST(64), .READ_LAT(2)
  ) u_fp (.Clock(clk), .Reset(rst), .bus(a.slave));

  sram_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(1), .MAX_BURST(4), .READ_LAT(2)
  ) u_rr (.Clock(clk), .Reset(rst), .bus(b.slave));

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t       gq[$];
  logic [3:0] rdq[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A write must never reach the SRAM while nobody owns the port
  always @(negedge clk) begin
    if (!rst && a.grant == '0)
      chk("a_we_unowned", 32'(a.SRAM_we_n), 1);
    if (!rst && b.grant == '0)
      chk("b_we_unowned", 32'(b.SRAM_we_n), 1);
  end

  initial begin
    exp_t e;
    int pulses;
    int first;
    int ha;
    int hb;

    a.req = '0; a.ch_addr = '0; a.ch_wdata = '0; a.ch_we_n = '1;
    b.req = '0; b.ch_addr = '0; b.ch_wdata = '0; b.ch_we_n = '1;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(a.grant), 0);
    chk("rst_busy", 32'(a.busy), 0);
    chk("rst_rd_valid", 32'(a.rd_valid), 0);
    chk("rst_we_n", 32'(a.SRAM_we_n), 1);
    chk("rst_addr", 32'(a.SRAM_address), 0);
    chk("rst_rr_grant", 32'(b.grant), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(a.busy), 0);

    // Fixed priority plus write passthrough
    a.ch_we_n = 4'b0000;
    a.ch_addr[1*AW +: AW]  = 18'd146944;
    a.ch_wdata[1*DW +: DW] = 16'hABCD;
    a.ch_addr[3*AW +: AW]  = 18'd7;
    a.req = 4'b1010;
    tick();
    chk("fp_grant_c1", 32'(a.grant), 'b0010);
    chk("fp_busy", 32'(a.busy), 1);
    chk("wr_addr", 32'(a.SRAM_address), 146944);
    chk("wr_data", 32'(a.SRAM_write_data), 'hABCD);
    chk("wr_we_n", 32'(a.SRAM_we_n), 0);
    tick();
    chk("fp_grant_c2", 32'(a.grant), 'b0010);
    a.req = 4'b1000;
    tick();
    chk("fp_turn_grant", 32'(a.grant), 0);
    chk("fp_turn_we_n", 32'(a.SRAM_we_n), 1);
    chk("fp_turn_busy", 32'(a.busy), 1);
    tick();
    chk("fp_grant_ch3", 32'(a.grant), 'b1000);
    chk("fp_addr_ch3", 32'(a.SRAM_address), 7);
    a.req = '0;
    tick();
    chk("fp_rel_grant", 32'(a.grant), 0);
    tick();
    chk("fp_idle_busy", 32'(a.busy), 0);

    // Round robin with MAX_BURST=4
    b.ch_we_n = 4'b0000;
    b.req = 4'b0101;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        e.tag = "rr_owned";
        e.v   = (r % 2 == 1) ? 32'h4 : 32'h1;
        gq.push_back(e);
      end
      e.tag = "rr_turn";
      e.v   = 32'h0;
      gq.push_back(e);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      e = gq.pop_front();
      chk(e.tag, 32'(b.grant), e.v);
      if (c == 14) b.req = '0;
    end
    tick();
    chk("rr_idle_busy", 32'(b.busy), 0);
    chk("rr_idle_grant", 32'(b.grant), 0);

    // Read tagging: ch3 reads 100..103
    a.ch_we_n = 4'b1111;
    a.ch_addr[3*AW +: AW] = 18'd100;
    a.req = 4'b1000;
    pulses = 0;
    first  = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 4) begin
        chk("rd_grant", 32'(a.grant), 'b1000);
        chk("rd_addr", 32'(a.SRAM_address), 32'(100 + c - 1));
        rdq.push_back(4'b1000);
        a.ch_addr[3*AW +: AW] = AW'(100 + c);
        if (c == 4) a.req = '0;
      end
      if (c == 5) chk("rd_turn_grant", 32'(a.grant), 0);
      if (a.rd_valid != '0) begin
        pulses++;
        if (first < 0) first = c;
        if (rdq.size() == 0)
          chk("rd_extra", 32'(a.rd_valid), 0);
        else
          chk("rd_valid", 32'(a.rd_valid), 32'(rdq.pop_front()));
      end
    end
    chk("rd_pulses", 32'(pulses), 4);
    chk("rd_first", 32'(first), 3);
    chk("rd_q_empty", 32'(rdq.size()), 0);

    // Lone requester keeps the port indefinitely
    a.ch_we_n = 4'b0000;
    b.ch_we_n = 4'b0000;
    a.req = 4'b0100;
    b.req = 4'b0100;
    ha = 0;
    hb = 0;
    tick();
    for (int c = 0; c < 300; c++) begin
      tick();
      if (a.grant == 4'b0100) ha++;
      if (b.grant == 4'b0100) hb++;
    end
    chk("ub_fp_held", 32'(ha), 300);
    chk("ub_rr_held", 32'(hb), 300);
    chk("ub_fp_sat", 32'(u_fp.burst_cnt), 64);
    chk("ub_rr_sat", 32'(u_rr.burst_cnt), 4);
    a.req = '0;
    b.req = '0;
    tick();
    tick();
    chk("ub_idle", 32'(a.busy), 0);

    // Reset while ch0 owns with reads in flight
    a.ch_we_n = 4'b1111;
    a.req = 4'b0001;
    tick();
    chk("mr_grant", 32'(a.grant), 'b0001);
    tick();
    rst = 1'b1;
    a.req = '0;
    tick();
    chk("mr_grant_rst", 32'(a.grant), 0);
    chk("mr_busy_rst", 32'(a.busy), 0);
    chk("mr_rd_rst", 32'(a.rd_valid), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mr_no_rd", 32'(a.rd_valid), 0);
    end
    a.ch_we_n = 4'b0000;
    a.req = 4'b0001;
    tick();
    chk("mr_restart_grant", 32'(a.grant), 'b0001);
    chk("mr_restart_busy", 32'(a.busy), 1);
    a.req = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
